// File: rtl/evt_window_tracker.sv
// evt_window_tracker: tracks trigger/acknowledge obligations in a FIFO
// and flags whether each acknowledge arrives inside [MIN_DLY:MAX_DLY]
// cycles after its trigger.
// Optional build macro: EVT_WIN_STRONG_EN. When it is defined, closing the
// evaluation window (en falling) with open obligations raises err_unsat.
// When it is undefined, those obligations are discarded silently.
// Every output is registered, so each pulse appears one cycle after the
// edge at which the DUT evaluated it.
module evt_window_tracker #(
   parameter int DEPTH   = 4,
   parameter int MIN_DLY = 2,
   parameter int MAX_DLY = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       trig,
   input  logic                       ack,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       busy,
   output logic                       done,
   output logic                       err_early,
   output logic                       err_late,
   output logic                       err_spur,
   output logic                       err_ovf,
   output logic                       err_unsat
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW = $clog2(MAX_DLY + 2);
   localparam int EW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
   localparam logic [AW-1:0] MAX_A   = AW'(MAX_DLY);
   localparam logic [EW-1:0] MIN_E   = EW'(MIN_DLY);
   localparam logic [EW-1:0] MAX_E   = EW'(MAX_DLY);

   // Each stored age counts the edges seen since the entry was pushed.
   // A freshly pushed entry holds 0 but is already one cycle old in the
   // cycle after its trigger, so the age of the head in the current cycle
   // is the stored value plus one.
   logic [AW-1:0] age_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] cnt_r;
   logic          en_q_r;
   logic          busy_r;
   logic          done_r;
   logic          early_r;
   logic          late_r;
   logic          spur_r;
   logic          ovf_r;
   logic          unsat_r;

   logic [EW-1:0] head_age_s;
   logic          empty_s;
   logic          full_s;
   logic          en_fall_s;
   logic          pop_s;
   logic          push_s;
   logic          done_s;
   logic          early_s;
   logic          late_s;
   logic          spur_s;
   logic          ovf_s;
   logic          unsat_s;
   logic [CW-1:0] cnt_nxt_s;

   // Circular pointer advance that also works for depths that are not a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == LAST_P) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Per-cycle decision: classify the head entry, then decide on push and overflow.
   always_comb begin
      head_age_s = {1'b0, age_r[rd_ptr_r]} + EW'(1);
      empty_s    = (cnt_r == {CW{1'b0}});
      full_s     = (cnt_r == DEPTH_C);
      en_fall_s  = en_q_r & ~en;
      pop_s      = 1'b0;
      push_s     = 1'b0;
      done_s     = 1'b0;
      early_s    = 1'b0;
      late_s     = 1'b0;
      spur_s     = 1'b0;
      ovf_s      = 1'b0;
      if (en) begin
         if (empty_s) begin
            // An ack never discharges a trigger from the same cycle.
            spur_s = ack;
         end else if (ack) begin
            pop_s = 1'b1;
            if (head_age_s < MIN_E) begin
               early_s = 1'b1;
            end else begin
               done_s = 1'b1;
            end
         end else if (head_age_s >= MAX_E) begin
            pop_s  = 1'b1;
            late_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
         if (trig) begin
            if (full_s && !pop_s) begin
               ovf_s = 1'b1;
            end else begin
               push_s = 1'b1;
            end
         end else begin
            push_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // Next occupancy: closing the window empties the FIFO, otherwise push/pop adjust it.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (en_fall_s) begin
         cnt_nxt_s = {CW{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
         endcase
      end
   end

   // End-of-window check: only the strong build reports obligations left open.
   always_comb begin
`ifdef EVT_WIN_STRONG_EN
      if (en_fall_s && !empty_s) begin
         unsat_s = 1'b1;
      end else begin
         unsat_s = 1'b0;
      end
`else
      unsat_s = 1'b0;
`endif
   end

   // State and output registers, with a synchronous reset that overrides every input.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
         en_q_r   <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         early_r  <= 1'b0;
         late_r   <= 1'b0;
         spur_r   <= 1'b0;
         ovf_r    <= 1'b0;
         unsat_r  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            age_r[i] <= {AW{1'b0}};
         end
      end else begin
         en_q_r  <= en;
         cnt_r   <= cnt_nxt_s;
         busy_r  <= (cnt_nxt_s != {CW{1'b0}});
         done_r  <= done_s;
         early_r <= early_s;
         late_r  <= late_s;
         spur_r  <= spur_s;
         ovf_r   <= ovf_s;
         unsat_r <= unsat_s;
         if (en_fall_s) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
         end else begin
            if (pop_s) begin
               rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_s) begin
               wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
         end
         // Ages move only while the window is open. They saturate so that unused slots stay bounded.
         for (int i = 0; i < DEPTH; i++) begin
            if (en) begin
               if (push_s && (wr_ptr_r == PW'(i))) begin
                  age_r[i] <= {AW{1'b0}};
               end else if (age_r[i] < MAX_A) begin
                  age_r[i] <= age_r[i] + AW'(1);
               end
            end
         end
      end
   end

   assign pending   = cnt_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err_early = early_r;
   assign err_late  = late_r;
   assign err_spur  = spur_r;
   assign err_ovf   = ovf_r;
   assign err_unsat = unsat_r;

endmodule

// File: tb/tb_evt_window_tracker.sv
// Directed testbench for evt_window_tracker with its default parameters
// (DEPTH=4, MIN_DLY=2, MAX_DLY=5). The expected err_unsat value depends on
// whether EVT_WIN_STRONG_EN is defined.
// Cycle c of a scenario is the cycle in which the inputs are driven. The
// outputs that result from cycle c are sampled 1 time unit after the edge
// that ends cycle c, which is cycle c+1 in the numbering used for outputs.
module tb_evt_window_tracker;

   logic       clk;
   logic       rst;
   logic       en;
   logic       trig;
   logic       ack;
   logic [2:0] pending;
   logic       busy;
   logic       done;
   logic       err_early;
   logic       err_late;
   logic       err_spur;
   logic       err_ovf;
   logic       err_unsat;

   int total;
   int bad;

   // Flag vector layout: {done, early, late, spur, ovf, unsat}.
   localparam logic [5:0] F_NONE  = 6'b000000;
   localparam logic [5:0] F_DONE  = 6'b100000;
   localparam logic [5:0] F_EARLY = 6'b010000;
   localparam logic [5:0] F_LATE  = 6'b001000;
   localparam logic [5:0] F_SPUR  = 6'b000100;
   localparam logic [5:0] F_OVF   = 6'b000010;
`ifdef EVT_WIN_STRONG_EN
   localparam logic [5:0] F_FALL  = 6'b000001;
`else
   localparam logic [5:0] F_FALL  = 6'b000000;
`endif

   evt_window_tracker dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .trig      (trig),
      .ack       (ack),
      .pending   (pending),
      .busy      (busy),
      .done      (done),
      .err_early (err_early),
      .err_late  (err_late),
      .err_spur  (err_spur),
      .err_ovf   (err_ovf),
      .err_unsat (err_unsat)
   );

   // Free-running clock with a period of 10 time units.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] flags();
      return {done, err_early, err_late, err_spur, err_ovf, err_unsat};
   endfunction

   // Drive one cycle of inputs, then sample just after the edge that ends the cycle.
   task automatic step(input logic t, input logic a, input logic e);
      trig = t;
      ack  = a;
      en   = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic t, input logic a, input logic e);
      rst = 1'b1;
      step(t, a, e);
      rst = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [5:0] f, input logic [2:0] p);
      check_val({tag, ".flags"}, 32'(flags()), 32'(f));
      check_val({tag, ".pend"},  32'(pending), 32'(p));
      check_val({tag, ".busy"},  32'(busy),    32'(p != 3'd0));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      en    = 1'b0;
      trig  = 1'b0;
      ack   = 1'b0;
      #2;

      // Reset state. Trig and ack are held high to show that reset overrides them.
      do_reset(1'b1, 1'b1, 1'b1);
      check_state("reset", F_NONE, 3'd0);

      // An ack three cycles after the trig falls inside the window.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check_state("ok3.c0", F_NONE, 3'd1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check_state("ok3.c2", F_NONE, 3'd1);
      step(1'b0, 1'b1, 1'b1);
      check_state("ok3.ack", F_DONE, 3'd0);
      step(1'b0, 1'b0, 1'b1);
      check_state("ok3.pulse1", F_NONE, 3'd0);

      // An ack at age 2 sits on the MIN_DLY boundary and counts as done.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check_state("min2", F_DONE, 3'd0);

      // An ack at age 1 is early.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check_state("early1", F_EARLY, 3'd0);

      // An ack at age 5 sits on the MAX_DLY boundary and still counts as done.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check_state("max5", F_DONE, 3'd0);

      // With no ack, the entry expires at age 5.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      check_state("late.age4", F_NONE, 3'd1);
      step(1'b0, 1'b0, 1'b1);
      check_state("late.age5", F_LATE, 3'd0);

      // Overflow: the fifth trig is dropped while the FIFO is full.
      do_reset(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
      check_state("ovf.fill", F_NONE, 3'd4);
      step(1'b1, 1'b0, 1'b1);
      check_state("ovf.drop", F_OVF, 3'd4);
      step(1'b0, 1'b0, 1'b1);
      check_state("ovf.headlate", F_LATE, 3'd3);

      // A trig and a pop in the same cycle on a full FIFO both take effect.
      do_reset(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check_state("fullswap", F_DONE, 3'd4);

      // Spurious acks, including an ack that arrives together with a trig on an empty FIFO.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check_state("spur.empty", F_SPUR, 3'd0);
      step(1'b1, 1'b1, 1'b1);
      check_state("spur.trigack", F_SPUR, 3'd1);
      step(1'b0, 1'b1, 1'b1);
      check_state("spur.next", F_EARLY, 3'd0);

      // Closing the window discards the obligations. Inputs are then ignored while en is low.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check_state("enfall", F_FALL, 3'd0);
      step(1'b1, 1'b1, 1'b0);
      check_state("enlow.ignore", F_NONE, 3'd0);

      // A reset in the middle of operation discards the open trigs with no late report afterwards.
      do_reset(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check_state("midrst.pre", F_NONE, 3'd2);
      do_reset(1'b1, 1'b0, 1'b1);
      check_state("midrst.c4", F_NONE, 3'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b1);
         check_state("midrst.after", F_NONE, 3'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
